inst_cache: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the instruction fetcher (IF) and MemCtrl.
//  IF presents a PC. A hit returns the instruction from the array.
//  A miss holds a word-read request to MemCtrl until MemCtrl pulses data back. The cache then fills the line and forwards the word.
//  A ROB refresh (mispredict flush) abandons any pending miss. Cached lines survive the refresh.

---
 rtl/inst_cache.sv | 132 +++++++++++++
 tb/tb_inst_cache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and MemCtrl.
// Latency: hit 1 cycle; miss 1 + MemCtrl read latency + 1 cycles.
// Backpressure: rdy_in low freezes everything; IF holds its request until the response pulse.
module inst_cache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rdy_if_in,
  input  logic [31:0] pc_if_in,
  output logic [31:0] inst_if_out,
  output logic        rdy_inst_if_out,
  output logic        rdy_inst_mc_out,
  output logic [31:0] addr_mc_out,
  input  logic [31:0] inst_mc_in,
  input  logic        rdy_inst_mc_in,
  input  logic        refresh_rob_cdb_in
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [31:0]         data_arr [LINES];

  // Lookup fields come straight from the fetch PC; fill fields from the
  // outstanding request address, which doubles as the latched miss PC.
  logic [INDEX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_BITS-1:0]   lk_tag, fill_tag;
  logic                  lk_hit;

  assign lk_idx   = pc_if_in[INDEX_BITS+1:2];
  assign lk_tag   = pc_if_in[31:INDEX_BITS+2];
  assign fill_idx = addr_mc_out[INDEX_BITS+1:2];
  assign fill_tag = addr_mc_out[31:INDEX_BITS+2];
  assign lk_hit   = valid[lk_idx] && (tag_arr[lk_idx] == lk_tag);

  // Byte-offset bits play no part in a word-granular cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_if_in[1:0];

  logic [31:0] inst_nxt, addr_nxt;
  logic        if_vld_nxt, mc_req_nxt, fill_en;

  // Next-state and registered-output decode; a flush overrides the state action.
  always_comb begin
    state_nxt  = state;
    inst_nxt   = inst_if_out;
    addr_nxt   = addr_mc_out;
    mc_req_nxt = rdy_inst_mc_out;
    if_vld_nxt = 1'b0;
    fill_en    = 1'b0;
    if (refresh_rob_cdb_in) begin
      // A fill landing with the flush is still correct data, so keep it.
      state_nxt  = IDLE;
      mc_req_nxt = 1'b0;
      fill_en    = (state == MISS) && rdy_inst_mc_in;
    end else begin
      case (state)
        IDLE: begin
          // Skip the lookup in the pulse cycle so the held request is not answered twice.
          if (rdy_if_in && !rdy_inst_if_out) begin
            if (lk_hit) begin
              inst_nxt   = data_arr[lk_idx];
              if_vld_nxt = 1'b1;
            end else begin
              addr_nxt   = {pc_if_in[31:2], 2'b00};
              mc_req_nxt = 1'b1;
              state_nxt  = MISS;
            end
          end
        end
        MISS: begin
          if (rdy_inst_mc_in) begin
            fill_en    = 1'b1;
            inst_nxt   = inst_mc_in;
            if_vld_nxt = 1'b1;
            mc_req_nxt = 1'b0;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register, frozen while the global enable is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else if (rdy_in) begin
      state <= state_nxt;
    end
  end

  // Output registers and valid bits; reset drops any pending request immediately.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid           <= '0;
      inst_if_out     <= '0;
      rdy_inst_if_out <= 1'b0;
      rdy_inst_mc_out <= 1'b0;
      addr_mc_out     <= '0;
    end else if (rdy_in) begin
      inst_if_out     <= inst_nxt;
      rdy_inst_if_out <= if_vld_nxt;
      rdy_inst_mc_out <= mc_req_nxt;
      addr_mc_out     <= addr_nxt;
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= inst_mc_in;
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: table of fetches plus hand-written flush/stall/reset sequences.
// Inputs are driven on the falling edge and outputs sampled on the falling edge.
// MemCtrl is modelled by the bench, answering each miss two cycles after the request.
module tb_inst_cache;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        rdy_if_in;
  logic [31:0] pc_if_in;
  logic [31:0] inst_if_out;
  logic        rdy_inst_if_out;
  logic        rdy_inst_mc_out;
  logic [31:0] addr_mc_out;
  logic [31:0] inst_mc_in;
  logic        rdy_inst_mc_in;
  logic        refresh_rob_cdb_in;

  int total = 0;
  int bad   = 0;

  inst_cache #(.INDEX_BITS(8)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .rdy_if_in          (rdy_if_in),
    .pc_if_in           (pc_if_in),
    .inst_if_out        (inst_if_out),
    .rdy_inst_if_out    (rdy_inst_if_out),
    .rdy_inst_mc_out    (rdy_inst_mc_out),
    .addr_mc_out        (addr_mc_out),
    .inst_mc_in         (inst_mc_in),
    .rdy_inst_mc_in     (rdy_inst_mc_in),
    .refresh_rob_cdb_in (refresh_rob_cdb_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    bit          miss;
    logic [31:0] inst;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One complete fetch; on a miss the bench plays MemCtrl and returns 'word'.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] word, input bit miss,
                       input logic [31:0] inst, input logic [31:0] addr, input string nm);
    rdy_if_in = 1'b1;
    pc_if_in  = pc;
    @(negedge clk_in);
    if (!miss) begin
      check({nm, " hit pulse"}, 32'(rdy_inst_if_out), 32'd1);
      check({nm, " hit inst"}, inst_if_out, inst);
      check({nm, " hit no mc req"}, 32'(rdy_inst_mc_out), 32'd0);
    end else begin
      check({nm, " miss no pulse"}, 32'(rdy_inst_if_out), 32'd0);
      check({nm, " miss mc req"}, 32'(rdy_inst_mc_out), 32'd1);
      check({nm, " miss addr"}, addr_mc_out, addr);
      repeat (2) @(negedge clk_in);
      check({nm, " req held"}, 32'(rdy_inst_mc_out), 32'd1);
      rdy_inst_mc_in = 1'b1;
      inst_mc_in     = word;
      @(negedge clk_in);
      rdy_inst_mc_in = 1'b0;
      inst_mc_in     = '0;
      check({nm, " fill pulse"}, 32'(rdy_inst_if_out), 32'd1);
      check({nm, " fill inst"}, inst_if_out, inst);
      check({nm, " fill req drop"}, 32'(rdy_inst_mc_out), 32'd0);
    end
    rdy_if_in = 1'b0;
    @(negedge clk_in);
    check({nm, " pulse one cycle"}, 32'(rdy_inst_if_out), 32'd0);
  endtask

  initial begin
    // pc, MemCtrl word, expect miss, expected instruction, expected request address
    vecs[0]  = '{32'h0000_1004, 32'h0050_0093, 1'b1, 32'h0050_0093, 32'h0000_1004};
    vecs[1]  = '{32'h0000_1004, 32'h0000_0000, 1'b0, 32'h0050_0093, 32'h0000_0000};
    vecs[2]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 32'h1111_1111, 32'h0000_0000};
    vecs[3]  = '{32'h0000_0400, 32'h2222_2222, 1'b1, 32'h2222_2222, 32'h0000_0400};
    vecs[4]  = '{32'h0000_0000, 32'h1111_1111, 1'b1, 32'h1111_1111, 32'h0000_0000};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1111_1111, 32'h0000_0000};
    vecs[6]  = '{32'h0000_0403, 32'h3333_3333, 1'b1, 32'h3333_3333, 32'h0000_0400};
    vecs[7]  = '{32'h0000_1007, 32'h0000_0000, 1'b0, 32'h0050_0093, 32'h0000_0000};
    vecs[8]  = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFC};
    vecs[9]  = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[10] = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 32'h0000_03FC};
    vecs[11] = '{32'hFFFF_FFFE, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFC};

    rst_in             = 1'b0;
    rdy_in             = 1'b1;
    rdy_if_in          = 1'b0;
    pc_if_in           = '0;
    inst_mc_in         = '0;
    rdy_inst_mc_in     = 1'b0;
    refresh_rob_cdb_in = 1'b0;

    repeat (3) @(negedge clk_in);
    check("reset if pulse", 32'(rdy_inst_if_out), 32'd0);
    check("reset mc req", 32'(rdy_inst_mc_out), 32'd0);
    check("reset inst", inst_if_out, 32'd0);
    check("reset addr", addr_mc_out, 32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    for (int i = 0; i < 12; i++) begin
      fetch(vecs[i].pc, vecs[i].word, vecs[i].miss, vecs[i].inst, vecs[i].addr,
            $sformatf("vec%0d", i));
    end

    // Flush three cycles into a miss, then a stray MemCtrl pulse with nothing pending.
    rdy_if_in = 1'b1;
    pc_if_in  = 32'h0000_2000;
    @(negedge clk_in);
    check("flush mid-miss req up", 32'(rdy_inst_mc_out), 32'd1);
    @(negedge clk_in);
    refresh_rob_cdb_in = 1'b1;
    rdy_if_in          = 1'b0;
    @(negedge clk_in);
    refresh_rob_cdb_in = 1'b0;
    check("flush mid-miss req drop", 32'(rdy_inst_mc_out), 32'd0);
    check("flush mid-miss no pulse", 32'(rdy_inst_if_out), 32'd0);
    rdy_inst_mc_in = 1'b1;
    inst_mc_in     = 32'h7777_7777;
    @(negedge clk_in);
    rdy_inst_mc_in = 1'b0;
    inst_mc_in     = '0;
    check("stray mc pulse ignored", 32'(rdy_inst_if_out), 32'd0);
    check("stray mc pulse no req", 32'(rdy_inst_mc_out), 32'd0);
    fetch(32'h0000_2000, 32'h4444_4444, 1'b1, 32'h4444_4444, 32'h0000_2000, "after flush");

    // Flush in the same cycle as the fill: line is kept, IF gets nothing.
    rdy_if_in = 1'b1;
    pc_if_in  = 32'h0000_3000;
    @(negedge clk_in);
    check("flush+fill req up", 32'(rdy_inst_mc_out), 32'd1);
    @(negedge clk_in);
    rdy_inst_mc_in     = 1'b1;
    inst_mc_in         = 32'h5555_5555;
    refresh_rob_cdb_in = 1'b1;
    rdy_if_in          = 1'b0;
    @(negedge clk_in);
    rdy_inst_mc_in     = 1'b0;
    inst_mc_in         = '0;
    refresh_rob_cdb_in = 1'b0;
    check("flush+fill no pulse", 32'(rdy_inst_if_out), 32'd0);
    check("flush+fill req drop", 32'(rdy_inst_mc_out), 32'd0);
    @(negedge clk_in);
    check("flush+fill still quiet", 32'(rdy_inst_if_out), 32'd0);
    fetch(32'h0000_3000, 32'h0, 1'b0, 32'h5555_5555, 32'h0, "flush+fill rehit");

    // Global stall for four cycles during a miss with a masked MemCtrl pulse.
    rdy_if_in = 1'b1;
    pc_if_in  = 32'h0000_4000;
    @(negedge clk_in);
    check("stall req up", 32'(rdy_inst_mc_out), 32'd1);
    rdy_in         = 1'b0;
    rdy_inst_mc_in = 1'b1;
    inst_mc_in     = 32'h9999_9999;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      rdy_inst_mc_in = 1'b0;
      inst_mc_in     = '0;
      check($sformatf("stall%0d req", i), 32'(rdy_inst_mc_out), 32'd1);
      check($sformatf("stall%0d addr", i), addr_mc_out, 32'h0000_4000);
      check($sformatf("stall%0d no pulse", i), 32'(rdy_inst_if_out), 32'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("stall masked fill", 32'(rdy_inst_mc_out), 32'd1);
    rdy_inst_mc_in = 1'b1;
    inst_mc_in     = 32'h6666_6666;
    @(negedge clk_in);
    rdy_inst_mc_in = 1'b0;
    inst_mc_in     = '0;
    check("stall fill pulse", 32'(rdy_inst_if_out), 32'd1);
    check("stall fill inst", inst_if_out, 32'h6666_6666);
    check("stall fill req drop", 32'(rdy_inst_mc_out), 32'd0);
    rdy_if_in = 1'b0;
    @(negedge clk_in);
    fetch(32'h0000_4000, 32'h0, 1'b0, 32'h6666_6666, 32'h0, "stall rehit");

    // A stall during the response pulse holds the pulse.
    rdy_if_in = 1'b1;
    pc_if_in  = 32'h0000_4000;
    @(negedge clk_in);
    check("pulse freeze before", 32'(rdy_inst_if_out), 32'd1);
    rdy_in    = 1'b0;
    rdy_if_in = 1'b0;
    @(negedge clk_in);
    check("pulse freeze held", 32'(rdy_inst_if_out), 32'd1);
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("pulse freeze release", 32'(rdy_inst_if_out), 32'd0);

    // Asynchronous reset in the middle of a miss.
    rdy_if_in = 1'b1;
    pc_if_in  = 32'h0000_5000;
    @(negedge clk_in);
    check("arst req up", 32'(rdy_inst_mc_out), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("arst req drop", 32'(rdy_inst_mc_out), 32'd0);
    check("arst addr", addr_mc_out, 32'd0);
    rdy_if_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    fetch(32'h0000_1004, 32'h0050_0093, 1'b1, 32'h0050_0093, 32'h0000_1004, "after arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
